rv32c_fetch_queue: RTL and testbench

Parametrised RV32C fetch front-end that sits between the instruction-memory port and decode. It replaces the single-halfword fetch buffer with a DEPTH-halfword circular queue. It keeps one word request outstanding and re-aligns mixed 16/32-bit instructions, including 32-bit instructions that straddle a word boundary. Each instruction is presented to decode with its PC over a valid/ready handshake, and a redirect flushes the queue and drops stale in-flight data.

---
 rtl/rv32c_fetch_pkg.sv | 17 +
 rtl/rv32c_hw_queue.sv | 61 ++++++
 rtl/rv32c_fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_rv32c_fetch_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32c_fetch_pkg.sv
// Shared types and helpers for the RV32C fetch queue: fetch FSM states,
// halfword width and the compressed-encoding test.
package rv32c_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fstate_t;

  localparam int HW_W = 16;

  function automatic logic is_compressed(input logic [HW_W-1:0] hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/rv32c_hw_queue.sv
// DEPTH-entry circular halfword queue: 0/1/2 pushes and 0/1/2 pops per cycle,
// flush to empty, and a view of the two oldest halfwords.
module rv32c_hw_queue
  import rv32c_fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic [1:0]      i_push_n,
  input  logic [HW_W-1:0] i_push_hw0,
  input  logic [HW_W-1:0] i_push_hw1,
  input  logic [1:0]      i_pop_n,
  output logic [CW-1:0]   o_count,
  output logic [HW_W-1:0] o_hw0,
  output logic [HW_W-1:0] o_hw1
);

  logic [HW_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_tail_p1;
  logic [PW-1:0]   w_head_p1;

  assign w_tail_p1 = r_tail + PW'(1);
  assign w_head_p1 = r_head + PW'(1);

  // Pointer and occupancy update; a push and a pop in one cycle both apply.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= PW'(0);
      r_tail  <= PW'(0);
      r_count <= CW'(0);
    end else begin
      r_head  <= r_head + PW'(i_pop_n);
      r_tail  <= r_tail + PW'(i_push_n);
      r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
    end
  end

  // Storage write; the first pushed halfword lands at the tail.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush) begin
      if (i_push_n != 2'd0) begin
        r_mem[r_tail] <= i_push_hw0;
      end
      if (i_push_n == 2'd2) begin
        r_mem[w_tail_p1] <= i_push_hw1;
      end
    end
  end

  assign o_count = r_count;
  assign o_hw0   = r_mem[r_head];
  assign o_hw1   = r_mem[w_head_p1];

endmodule

// File: rtl/rv32c_fetch_queue.sv
// RV32C fetch front-end: single-outstanding word fetch into a halfword queue,
// 16/32-bit re-alignment at the head, and redirect flush with stale-data drop.
module rv32c_fetch_queue
  import rv32c_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          DEPTH    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_dec_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_dec_inst,
  output logic [31:0] o_dec_pc,
  output logic        o_dec_is_c
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

  fstate_t     r_fstate;
  logic [31:0] r_fetch_pc;
  logic        r_skip_low;
  logic [31:0] r_dec_pc;
  logic [31:0] r_last_inst;
  logic        r_last_is_c;

  logic [CW-1:0]   w_count;
  logic [HW_W-1:0] w_hw0;
  logic [HW_W-1:0] w_hw1;
  logic            w_is_c;
  logic [31:0]     w_inst;
  logic            w_head_ok;
  logic [CW:0]     w_inflight;
  logic [CW:0]     w_used;
  logic            w_flush;
  logic            w_push;
  logic            w_pop;
  logic            w_fire_gnt;
  logic [1:0]      w_push_n;
  logic [HW_W-1:0] w_push_hw0;
  logic [HW_W-1:0] w_push_hw1;
  logic [1:0]      w_pop_n;
  logic            w_unused;

  assign w_unused = i_redirect_pc[0];

  rv32c_hw_queue #(.DEPTH(DEPTH)) u_queue (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_redirect_en),
    .i_push_n   (w_push_n),
    .i_push_hw0 (w_push_hw0),
    .i_push_hw1 (w_push_hw1),
    .i_pop_n    (w_pop_n),
    .o_count    (w_count),
    .o_hw0      (w_hw0),
    .o_hw1      (w_hw1)
  );

  // Head decode: a 32-bit instruction needs both halves resident.
  assign w_is_c    = is_compressed(w_hw0);
  assign w_inst    = w_is_c ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
  assign w_head_ok = w_is_c ? (w_count != CW'(0)) : (w_count >= CW'(2));

  // Halfwords already promised to the queue by the outstanding request.
  assign w_inflight = (r_fstate == WAIT) ? (r_skip_low ? (CW+1)'(1) : (CW+1)'(2))
                                         : (CW+1)'(0);
  assign w_used     = {1'b0, w_count} + w_inflight;

  assign w_flush     = i_rst | i_redirect_en;
  assign o_imem_req  = (r_fstate == IDLE) && ((w_used + (CW+1)'(2)) <= LP_DEPTH) && !w_flush;
  assign o_imem_addr = r_fetch_pc;
  assign o_dec_valid = w_head_ok && !w_flush;
  assign o_dec_inst  = w_head_ok ? w_inst : r_last_inst;
  assign o_dec_is_c  = w_head_ok ? w_is_c : r_last_is_c;
  assign o_dec_pc    = r_dec_pc;

  assign w_fire_gnt = o_imem_req && i_imem_gnt;
  assign w_push     = (r_fstate == WAIT) && i_imem_rvalid && !w_flush;
  assign w_pop      = o_dec_valid && i_dec_ready;

  // Queue push/pop sizing; a misaligned target drops the low halfword.
  always_comb begin
    w_push_n   = 2'd0;
    w_push_hw0 = i_imem_rdata[15:0];
    w_push_hw1 = i_imem_rdata[31:16];
    w_pop_n    = 2'd0;
    if (w_push) begin
      if (r_skip_low) begin
        w_push_n   = 2'd1;
        w_push_hw0 = i_imem_rdata[31:16];
      end else begin
        w_push_n = 2'd2;
      end
    end else begin
      w_push_n = 2'd0;
    end
    if (w_pop) begin
      w_pop_n = w_is_c ? 2'd1 : 2'd2;
    end else begin
      w_pop_n = 2'd0;
    end
  end

  // Fetch FSM, PCs and the held decode value; redirect outranks everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fstate    <= IDLE;
      r_fetch_pc  <= {RESET_PC[31:2], 2'b00};
      r_skip_low  <= RESET_PC[1];
      r_dec_pc    <= {RESET_PC[31:1], 1'b0};
      r_last_inst <= 32'h0000_0000;
      r_last_is_c <= 1'b0;
    end else if (i_redirect_en) begin
      r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
      r_skip_low <= i_redirect_pc[1];
      r_dec_pc   <= {i_redirect_pc[31:1], 1'b0};
      // A response still owed by the fabric must be swallowed in DROP.
      case (r_fstate)
        IDLE:    r_fstate <= i_imem_gnt ? DROP : IDLE;
        WAIT:    r_fstate <= i_imem_rvalid ? IDLE : DROP;
        DROP:    r_fstate <= i_imem_rvalid ? IDLE : DROP;
        default: r_fstate <= IDLE;
      endcase
    end else begin
      case (r_fstate)
        IDLE: begin
          if (w_fire_gnt) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_fstate   <= WAIT;
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            r_skip_low <= 1'b0;
            r_fstate   <= IDLE;
          end
        end
        DROP: begin
          if (i_imem_rvalid) begin
            r_fstate <= IDLE;
          end
        end
        default: r_fstate <= IDLE;
      endcase
      if (w_pop) begin
        r_dec_pc <= r_dec_pc + (w_is_c ? 32'd2 : 32'd4);
      end
      if (w_head_ok) begin
        r_last_inst <= w_inst;
        r_last_is_c <= w_is_c;
      end
    end
  end

endmodule

// File: tb/tb_rv32c_fetch_queue.sv
// Directed self-checking bench for rv32c_fetch_queue (DEPTH=8, RESET_PC=0x200).
module tb_rv32c_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_is_c;

  int n_checks = 0;
  int n_fail   = 0;

  rv32c_fetch_queue #(.RESET_PC(32'h0000_0200), .DEPTH(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_redirect_en (redirect_en),
    .i_redirect_pc (redirect_pc),
    .o_dec_valid   (dec_valid),
    .i_dec_ready   (dec_ready),
    .o_dec_inst    (dec_inst),
    .o_dec_pc      (dec_pc),
    .o_dec_is_c    (dec_is_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full bus transaction: grant now, data in the following cycle.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data);
    chk1("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, addr);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
  endtask

  // Check the head instruction, then consume it.
  task automatic pop_chk(input logic [31:0] inst, input logic [31:0] pc, input logic is_c);
    chk1("dec_valid", dec_valid, 1'b1);
    chk("dec_inst", dec_inst, inst);
    chk("dec_pc", dec_pc, pc);
    chk1("dec_is_c", dec_is_c, is_c);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic [31:0] exp_addr);
    redirect_en = 1'b1;
    redirect_pc = pc;
    #1;
    chk1("redir_req_gated", imem_req, 1'b0);
    chk1("redir_valid_gated", dec_valid, 1'b0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    chk("redir_addr", imem_addr, exp_addr);
    chk("redir_dec_pc", dec_pc, {pc[31:1], 1'b0});
  endtask

  initial begin
    logic [15:0] hw_lo;
    logic [15:0] hw_hi;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_en = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h200);
    chk1("rst_valid", dec_valid, 1'b0);
    chk("rst_inst", dec_inst, 32'h0);
    chk("rst_pc", dec_pc, 32'h200);
    chk1("rst_is_c", dec_is_c, 1'b0);
    rst = 1'b0;
    #1;
    chk1("req_after_rst", imem_req, 1'b1);

    // Mixed 16/32-bit stream.
    fetch_word(32'h200, 32'h0001_4501);
    pop_chk(32'h0000_4501, 32'h200, 1'b1);
    pop_chk(32'h0000_0001, 32'h202, 1'b1);
    chk1("empty_valid", dec_valid, 1'b0);
    chk("empty_hold_inst", dec_inst, 32'h0000_0001);
    fetch_word(32'h204, 32'h0000_0513);
    pop_chk(32'h0000_0513, 32'h204, 1'b0);

    // 32-bit instruction straddling two responses.
    do_redirect(32'h300, 32'h300);
    fetch_word(32'h300, 32'h0513_4501);
    pop_chk(32'h0000_4501, 32'h300, 1'b1);
    chk1("straddle_held", dec_valid, 1'b0);
    fetch_word(32'h304, 32'h0000_0000);
    pop_chk(32'h0000_0513, 32'h302, 1'b0);

    // Misaligned redirect skips the low halfword.
    do_redirect(32'h402, 32'h400);
    fetch_word(32'h400, 32'hABCD_4501);
    pop_chk(32'h0000_ABCD, 32'h402, 1'b1);
    chk1("misalign_empty", dec_valid, 1'b0);
    chk("misalign_next_addr", imem_addr, 32'h404);

    // Redirect while WAIT: late response is dropped.
    do_redirect(32'h200, 32'h200);
    chk1("wait_req", imem_req, 1'b1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h800;
    #1;
    chk1("wait_redir_req", imem_req, 1'b0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    chk1("drop_req", imem_req, 1'b0);
    chk("drop_addr", imem_addr, 32'h800);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    #1;
    chk1("drop_rvalid_req", imem_req, 1'b0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk1("drop_no_valid", dec_valid, 1'b0);
    chk1("drop_back_idle", imem_req, 1'b1);
    chk("drop_pc", dec_pc, 32'h800);
    fetch_word(32'h800, 32'h0000_4501);
    pop_chk(32'h0000_4501, 32'h800, 1'b1);
    pop_chk(32'h0000_0000, 32'h802, 1'b1);

    // Backpressure until full, then drain.
    for (int i = 0; i < 4; i++) begin
      hw_lo = 16'h4001 + 16'(32 * i);
      hw_hi = 16'h4001 + 16'(32 * i + 16);
      fetch_word(32'h804 + 32'(4 * i), {hw_hi, hw_lo});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk1("full_no_req", imem_req, 1'b0);
    end
    chk("full_addr", imem_addr, 32'h814);
    for (int j = 0; j < 8; j++) begin
      chk1("drain_req", imem_req, (j >= 2));
      pop_chk({16'h0000, 16'h4001 + 16'(16 * j)}, 32'h804 + 32'(2 * j), 1'b1);
    end
    chk1("drained", dec_valid, 1'b0);

    // Push and pop in the same cycle.
    fetch_word(32'h814, 32'h0009_0005);
    chk1("sim_req", imem_req, 1'b1);
    chk("sim_addr", imem_addr, 32'h818);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h000D_0011;
    dec_ready   = 1'b1;
    #1;
    chk("sim_head", dec_inst, 32'h0000_0005);
    chk("sim_head_pc", dec_pc, 32'h814);
    @(negedge clk);
    imem_rvalid = 1'b0;
    dec_ready   = 1'b0;
    #1;
    pop_chk(32'h0000_0009, 32'h816, 1'b1);
    pop_chk(32'h0000_0011, 32'h818, 1'b1);
    pop_chk(32'h0000_000D, 32'h81A, 1'b1);
    chk1("sim_count_empty", dec_valid, 1'b0);

    // Response arriving in the redirect cycle is dropped; FSM returns to IDLE.
    chk("rr_addr", imem_addr, 32'h81C);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2222_2221;
    redirect_en = 1'b1;
    redirect_pc = 32'h900;
    #1;
    chk1("rr_valid_gated", dec_valid, 1'b0);
    chk1("rr_req_gated", imem_req, 1'b0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    redirect_en = 1'b0;
    #1;
    chk1("rr_idle_req", imem_req, 1'b1);
    chk("rr_addr_new", imem_addr, 32'h900);
    chk1("rr_no_stale", dec_valid, 1'b0);
    chk("rr_dec_pc", dec_pc, 32'h900);
    fetch_word(32'h900, 32'h0000_4501);
    pop_chk(32'h0000_4501, 32'h900, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
